reset_sequencer: RTL and testbench
==================================

Name: reset_sequencer

Overview:
Parametrised successor to the single-output clock/reset block. It runs in the selected system clock domain and drives NUM_DOMAINS active-low domain resets. Resets are held while the clock source is unlocked, stretched for a programmable time, then released one domain at a time in ascending index order. It also supports masked software resets of individual domains and re-sequences automatically when lock is lost.

Parameters:
NUM_DOMAINS, 4, number of reset outputs (legal range 1..32)
STRETCH_CYCLES, 16, consecutive locked cycles in ASSERT before the first release (>=1)
STAGGER_CYCLES, 4, cycles between successive domain releases (>=1)

Ports:
CLK  in  1  sole clock (selected system clock)
RESET  in  1  synchronous, active-high reset
LOCK  in  1  clock source stable/locked, sampled every cycle
SW_RST_REQ  in  1  single-cycle software reset request
SW_RST_MASK  in  NUM_DOMAINS  domains to reset; sampled only with SW_RST_REQ
RESETn_OUT  out  NUM_DOMAINS  registered active-low domain resets
RST_DONE  out  1  high when every domain is released
BUSY  out  1  high when state != DONE
LOCK_LOST  out  1  one-cycle pulse when LOCK falls in RELEASE or DONE

Behaviour:
- Clocking and reset: one clock, CLK. Reset is RESET, synchronous and active-high. All outputs are registered.
- While RESET=1, on every edge:
  - RESETn_OUT=0, RST_DONE=0, BUSY=1, LOCK_LOST=0
  - state=ASSERT, pending=all ones, stretch and stagger counters=0
- State ASSERT:
  - Pending domains are held low.
  - The stretch counter increments on each cycle with LOCK=1 and clears to 0 on any cycle with LOCK=0.
  - On a locked cycle with counter==STRETCH_CYCLES-1, the same edge releases the lowest-index pending domain and moves to RELEASE.
  - Timing: the first release is visible STRETCH_CYCLES cycles after the first ASSERT cycle, with LOCK high throughout.
- State RELEASE:
  - The stagger counter counts 0..STAGGER_CYCLES-1.
  - At wrap, the next lowest-index pending domain is released.
  - Non-pending domains are skipped and do not consume a stagger slot.
  - The k-th pending domain (k from 0) is visible high at ASSERT entry + STRETCH_CYCLES + k*STAGGER_CYCLES.
  - The edge that releases the last pending domain also sets RST_DONE=1, clears pending, and moves to DONE.
- State DONE:
  - All outputs are high. RST_DONE=1, BUSY=0.
- Software request (SW_RST_REQ=1 with SW_RST_MASK!=0):
  - Valid in any state.
  - Next edge: pending |= mask, masked outputs go low, RST_DONE=0, state=ASSERT, both counters clear.
  - Already-released unmasked domains stay high.
  - A request with mask=0 is ignored.
- Lock loss (LOCK=0 while in RELEASE or DONE):
  - Next edge: pending = all ones, all outputs low, state=ASSERT, counters clear, LOCK_LOST pulses for 1 cycle.
  - In ASSERT, LOCK=0 only clears the stretch counter.
- Priority: RESET > lock loss > software request > normal sequencing.
  - A software request in the same cycle as lock loss is absorbed by the full re-sequence.
- Mid-operation RESET: all outputs drop low on the next edge, regardless of state.
- Out-of-range parameters: elaboration error.

Decomposition:
- Package rst_seq_pkg:
  - state enum {ASSERT, RELEASE, DONE}
  - function clog2-based counter width: max(1, $clog2(max(STRETCH_CYCLES, STAGGER_CYCLES)))
  - parameter range-check constants
- Sub-module rst_seq_prio_pick: combinational lowest-set-bit one-hot picker over pending. Used by the release step and by skip logic.
- The FSM, counters and output registers stay in reset_sequencer.

Test Plan:
All scenarios use defaults N=4, STRETCH=16, STAGGER=4; cycle 0 is the first cycle with RESET=0.
1. LOCK=1 throughout, RESET low at cycle 0 -> RESETn_OUT[0..3] rise at cycles 16/20/24/28; RST_DONE=1 and BUSY=0 at 28.
2. LOCK=0 for cycles 0..9, high from 10; also a LOCK=0 glitch at cycle 12 -> stretch restarts at 13; OUT[0] rises at 29, OUT[3] at 41.
3. In DONE, SW_RST_REQ with mask 4'b1010 at cycle c -> OUT[1],[3] low at c+1; OUT[1] high at c+17, OUT[3] high at c+21 (skips bit 2); OUT[0],[2] never drop; RST_DONE at c+21.
4. LOCK falls at cycle 22 during RELEASE -> all outputs low at 23, LOCK_LOST=1 for exactly cycle 23; with LOCK restored at 23, OUT[0] high at 39.
5. SW_RST_REQ mask 4'b0001 and LOCK=0 in the same DONE cycle -> full re-sequence, all four outputs low, LOCK_LOST pulses; also check that a request with mask 0 has no effect.
6. RESET asserted at cycle 21 (mid-RELEASE) -> all outputs 0 and BUSY=1 at 22; sequence restarts from ASSERT once RESET drops.

Source files
------------

// File: rtl/rst_seq_pkg.sv
// rtl/rst_seq_pkg.sv - shared types, limits and counter sizing for the reset sequencer
package rst_seq_pkg;

    typedef enum logic [1:0] {
        ST_ASSERT  = 2'd0,
        ST_RELEASE = 2'd1,
        ST_DONE    = 2'd2
    } state_t;

    localparam int MIN_DOMAINS = 1;
    localparam int MAX_DOMAINS = 32;
    localparam int MIN_STRETCH = 1;
    localparam int MIN_STAGGER = 1;

    // One counter width serves both the stretch and stagger counters.
    function automatic int cnt_width(input int stretch, input int stagger);
        int longest;
        int w;
        longest = (stretch > stagger) ? stretch : stagger;
        w = $clog2(longest);
        return (w < 1) ? 1 : w;
    endfunction

endpackage

// File: rtl/rst_seq_prio_pick.sv
// rtl/rst_seq_prio_pick.sv - one-hot select of the lowest set bit of a request vector
module rst_seq_prio_pick #(
    parameter int WIDTH = 4
) (
    input  logic [WIDTH-1:0] req,
    output logic [WIDTH-1:0] grant
);

    // Two's complement isolates the lowest set bit; zero in gives zero out.
    assign grant = req & (~req + WIDTH'(1));

endmodule

// File: rtl/reset_sequencer.sv
// rtl/reset_sequencer.sv - multi-domain reset sequencer: hold while unlocked, stretch, staggered release
module reset_sequencer #(
    parameter int NUM_DOMAINS    = 4,
    parameter int STRETCH_CYCLES = 16,
    parameter int STAGGER_CYCLES = 4
) (
    input  logic                   CLK,
    input  logic                   RESET,
    input  logic                   LOCK,
    input  logic                   SW_RST_REQ,
    input  logic [NUM_DOMAINS-1:0] SW_RST_MASK,
    output logic [NUM_DOMAINS-1:0] RESETn_OUT,
    output logic                   RST_DONE,
    output logic                   BUSY,
    output logic                   LOCK_LOST
);
    import rst_seq_pkg::*;

    if (NUM_DOMAINS < MIN_DOMAINS || NUM_DOMAINS > MAX_DOMAINS) begin : g_bad_domains
        $error("reset_sequencer: NUM_DOMAINS must be within 1..32");
    end
    if (STRETCH_CYCLES < MIN_STRETCH) begin : g_bad_stretch
        $error("reset_sequencer: STRETCH_CYCLES must be at least 1");
    end
    if (STAGGER_CYCLES < MIN_STAGGER) begin : g_bad_stagger
        $error("reset_sequencer: STAGGER_CYCLES must be at least 1");
    end

    localparam int CW = cnt_width(STRETCH_CYCLES, STAGGER_CYCLES);
    localparam logic [CW-1:0] STRETCH_LAST = CW'(STRETCH_CYCLES - 1);
    localparam logic [CW-1:0] STAGGER_LAST = CW'(STAGGER_CYCLES - 1);

    state_t                   state;
    state_t                   state_n;
    logic [NUM_DOMAINS-1:0]   pending;
    logic [NUM_DOMAINS-1:0]   pending_n;
    logic [NUM_DOMAINS-1:0]   pick;
    logic [NUM_DOMAINS-1:0]   pending_rel;
    logic [CW-1:0]            stretch_cnt;
    logic [CW-1:0]            stretch_n;
    logic [CW-1:0]            stagger_cnt;
    logic [CW-1:0]            stagger_n;
    logic                     lock_drop;
    logic                     sw_hit;
    logic [NUM_DOMAINS-1:0]   resetn_n;
    logic                     done_n;
    logic                     busy_n;
    logic                     lock_lost_n;

    rst_seq_prio_pick #(
        .WIDTH (NUM_DOMAINS)
    ) u_pick (
        .req   (pending),
        .grant (pick)
    );

    assign pending_rel = pending & ~pick;
    assign lock_drop   = !LOCK && (state != ST_ASSERT);
    assign sw_hit      = SW_RST_REQ && (SW_RST_MASK != '0);

    always_ff @(posedge CLK) begin
        if (RESET) begin
            state       <= ST_ASSERT;
            pending     <= '1;
            stretch_cnt <= '0;
            stagger_cnt <= '0;
        end else begin
            state       <= state_n;
            pending     <= pending_n;
            stretch_cnt <= stretch_n;
            stagger_cnt <= stagger_n;
        end
    end

    // Lock loss outranks a software request, which outranks normal sequencing.
    always_comb begin
        state_n   = state;
        pending_n = pending;
        stretch_n = stretch_cnt;
        stagger_n = stagger_cnt;
        if (lock_drop) begin
            state_n   = ST_ASSERT;
            pending_n = '1;
            stretch_n = '0;
            stagger_n = '0;
        end else if (sw_hit) begin
            state_n   = ST_ASSERT;
            pending_n = pending | SW_RST_MASK;
            stretch_n = '0;
            stagger_n = '0;
        end else begin
            case (state)
                ST_ASSERT: begin
                    if (!LOCK) begin
                        stretch_n = '0;
                    end else if (stretch_cnt == STRETCH_LAST) begin
                        pending_n = pending_rel;
                        stretch_n = '0;
                        stagger_n = '0;
                        state_n   = (pending_rel == '0) ? ST_DONE : ST_RELEASE;
                    end else begin
                        stretch_n = stretch_cnt + CW'(1);
                    end
                end
                ST_RELEASE: begin
                    if (stagger_cnt == STAGGER_LAST) begin
                        pending_n = pending_rel;
                        stagger_n = '0;
                        state_n   = (pending_rel == '0) ? ST_DONE : ST_RELEASE;
                    end else begin
                        stagger_n = stagger_cnt + CW'(1);
                    end
                end
                ST_DONE: begin
                    pending_n = '0;
                end
                default: begin
                    state_n   = ST_ASSERT;
                    pending_n = '1;
                    stretch_n = '0;
                    stagger_n = '0;
                end
            endcase
        end
    end

    always_comb begin
        resetn_n    = ~pending_n;
        done_n      = (state_n == ST_DONE);
        busy_n      = (state_n != ST_DONE);
        lock_lost_n = lock_drop;
    end

    always_ff @(posedge CLK) begin
        if (RESET) begin
            RESETn_OUT <= '0;
            RST_DONE   <= 1'b0;
            BUSY       <= 1'b1;
            LOCK_LOST  <= 1'b0;
        end else begin
            RESETn_OUT <= resetn_n;
            RST_DONE   <= done_n;
            BUSY       <= busy_n;
            LOCK_LOST  <= lock_lost_n;
        end
    end

endmodule

// File: tb/tb_reset_sequencer.sv
// tb/tb_reset_sequencer.sv - directed bench for reset_sequencer with default parameters
module tb_reset_sequencer;

    logic       CLK;
    logic       RESET;
    logic       LOCK;
    logic       SW_RST_REQ;
    logic [3:0] SW_RST_MASK;
    logic [3:0] RESETn_OUT;
    logic       RST_DONE;
    logic       BUSY;
    logic       LOCK_LOST;

    reset_sequencer #(
        .NUM_DOMAINS    (4),
        .STRETCH_CYCLES (16),
        .STAGGER_CYCLES (4)
    ) dut (
        .CLK         (CLK),
        .RESET       (RESET),
        .LOCK        (LOCK),
        .SW_RST_REQ  (SW_RST_REQ),
        .SW_RST_MASK (SW_RST_MASK),
        .RESETn_OUT  (RESETn_OUT),
        .RST_DONE    (RST_DONE),
        .BUSY        (BUSY),
        .LOCK_LOST   (LOCK_LOST)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    int total = 0;
    int bad   = 0;
    int cyc   = 0;

    // Per-cycle stimulus schedule and expected low windows [fall, rise); index 4 is RST_DONE.
    bit         lock_low [0:127];
    int         sw_cyc;
    logic [3:0] sw_mask;
    int         rst_cyc;
    int         ll_cyc;
    int         fall [0:4];
    int         rise [0:4];

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge CLK);
        #1;
        cyc++;
    endtask

    task automatic clear_sched();
        for (int i = 0; i < 128; i++) lock_low[i] = 1'b0;
        sw_cyc  = -1;
        sw_mask = 4'b0000;
        rst_cyc = -1;
        ll_cyc  = -1;
    endtask

    task automatic set_dom(input int d, input int f, input int r);
        fall[d] = f;
        rise[d] = r;
    endtask

    task automatic expect_all(input int f, input int r0, input int r1, input int r2, input int r3, input int rd);
        set_dom(0, f, r0);
        set_dom(1, f, r1);
        set_dom(2, f, r2);
        set_dom(3, f, r3);
        set_dom(4, f, rd);
    endtask

    task automatic do_reset();
        clear_sched();
        RESET       = 1'b1;
        LOCK        = 1'b1;
        SW_RST_REQ  = 1'b0;
        SW_RST_MASK = 4'b0000;
        tick();
        tick();
        tick();
        chk("rst_out",  32'(RESETn_OUT), 32'h0);
        chk("rst_done", 32'(RST_DONE),   32'h0);
        chk("rst_busy", 32'(BUSY),       32'h1);
        chk("rst_ll",   32'(LOCK_LOST),  32'h0);
        RESET = 1'b0;
        cyc   = 0;
    endtask

    task automatic run_win(input int c0, input int c1);
        logic [3:0] exp_out;
        logic       exp_done;
        for (int c = c0; c <= c1; c++) begin
            while (cyc < c) tick();
            LOCK        = (c < 128) ? !lock_low[c] : 1'b1;
            SW_RST_REQ  = (c == sw_cyc);
            SW_RST_MASK = (c == sw_cyc) ? sw_mask : 4'b0000;
            RESET       = (c == rst_cyc);
            for (int d = 0; d < 4; d++) exp_out[d] = !(c >= fall[d] && c < rise[d]);
            exp_done = !(c >= fall[4] && c < rise[4]);
            chk($sformatf("out@%0d", c),  32'(RESETn_OUT), 32'(exp_out));
            chk($sformatf("done@%0d", c), 32'(RST_DONE),   32'(exp_done));
            chk($sformatf("busy@%0d", c), 32'(BUSY),       32'(!exp_done));
            chk($sformatf("ll@%0d", c),   32'(LOCK_LOST),  32'(c == ll_cyc));
        end
    endtask

    initial begin
        // Plain power-up sequence, locked throughout.
        do_reset();
        expect_all(0, 16, 20, 24, 28, 28);
        run_win(0, 30);

        // Software reset of domains 1 and 3 from DONE; domain 2 is skipped.
        sw_cyc  = 32;
        sw_mask = 4'b1010;
        set_dom(0, 999, 999);
        set_dom(1, 33, 49);
        set_dom(2, 999, 999);
        set_dom(3, 33, 53);
        set_dom(4, 33, 53);
        run_win(31, 55);

        // Late lock plus a one-cycle glitch restarts the stretch.
        do_reset();
        for (int i = 0; i < 10; i++) lock_low[i] = 1'b1;
        lock_low[12] = 1'b1;
        expect_all(0, 29, 33, 37, 41, 41);
        run_win(0, 43);

        // Lock lost during RELEASE forces a full re-sequence.
        do_reset();
        lock_low[22] = 1'b1;
        expect_all(0, 16, 20, 24, 28, 28);
        run_win(0, 22);
        ll_cyc = 23;
        expect_all(23, 39, 43, 47, 51, 51);
        run_win(23, 52);

        // Mask-zero request is ignored; request plus lock loss in DONE re-sequences everything.
        ll_cyc  = -1;
        sw_cyc  = 55;
        sw_mask = 4'b0000;
        expect_all(999, 999, 999, 999, 999, 999);
        run_win(53, 59);
        sw_cyc       = 60;
        sw_mask      = 4'b0001;
        lock_low[60] = 1'b1;
        ll_cyc       = 61;
        expect_all(61, 77, 81, 85, 89, 89);
        run_win(60, 91);

        // RESET mid-RELEASE drops every output and restarts from ASSERT.
        do_reset();
        rst_cyc = 21;
        expect_all(0, 16, 20, 24, 28, 28);
        run_win(0, 21);
        expect_all(22, 38, 42, 46, 50, 50);
        run_win(22, 52);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
